// File: rtl/entrada_digito.sv
// Keypad input stage: synchronises the enter button and digit switches,
// debounces the button and emits one insere/invalido pulse per press.
module entrada_digito #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       botao,
  input  logic [3:0] chaves,
  output logic       insere,
  output logic [3:0] numero,
  output logic       invalido
);

  typedef enum logic [1:0] {
    OCIOSO,
    CONFIRMA_PRESSAO,
    PRESSIONADO,
    CONFIRMA_SOLTURA
  } estado_t;

  localparam logic [CNT_W-1:0] LP_ALVO = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] LP_UM   = CNT_W'(1);

  logic             r_botao_m;
  logic             r_botao_s;
  logic [3:0]       r_chaves_m;
  logic [3:0]       r_chaves_s;
  estado_t          r_estado;
  logic [CNT_W-1:0] r_cnt;
  logic             r_insere;
  logic             r_invalido;
  logic [3:0]       r_numero;

  logic w_alvo;
  logic w_digito_ok;

  assign w_alvo      = (r_cnt >= LP_ALVO);
  assign w_digito_ok = (r_chaves_s <= 4'd9);

  assign insere   = r_insere;
  assign invalido = r_invalido;
  assign numero   = r_numero;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_botao_m  <= 1'b0;
      r_botao_s  <= 1'b0;
      r_chaves_m <= 4'd0;
      r_chaves_s <= 4'd0;
    end else begin
      r_botao_m  <= botao;
      r_botao_s  <= r_botao_m;
      r_chaves_m <= chaves;
      r_chaves_s <= r_chaves_m;
    end
  end

  // Starting in CONFIRMA_SOLTURA forces a clean release after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_estado   <= CONFIRMA_SOLTURA;
      r_cnt      <= '0;
      r_insere   <= 1'b0;
      r_invalido <= 1'b0;
      r_numero   <= 4'd0;
    end else begin
      r_insere   <= 1'b0;
      r_invalido <= 1'b0;
      case (r_estado)
        OCIOSO: begin
          if (r_botao_s) begin
            r_estado <= CONFIRMA_PRESSAO;
            r_cnt    <= LP_UM;
          end
        end
        CONFIRMA_PRESSAO: begin
          if (!r_botao_s) begin
            r_estado <= OCIOSO;
            r_cnt    <= '0;
          end else if (!w_alvo) begin
            r_cnt <= r_cnt + LP_UM;
          end else begin
            r_estado <= PRESSIONADO;
            r_cnt    <= '0;
            if (w_digito_ok) begin
              r_numero <= r_chaves_s;
              r_insere <= 1'b1;
            end else begin
              r_invalido <= 1'b1;
            end
          end
        end
        PRESSIONADO: begin
          if (!r_botao_s) begin
            r_estado <= CONFIRMA_SOLTURA;
            r_cnt    <= LP_UM;
          end
        end
        CONFIRMA_SOLTURA: begin
          if (r_botao_s) begin
            r_cnt <= '0;
          end else if (!w_alvo) begin
            r_cnt <= r_cnt + LP_UM;
          end else begin
            r_estado <= OCIOSO;
            r_cnt    <= '0;
          end
        end
        default: begin
          r_estado <= CONFIRMA_SOLTURA;
          r_cnt    <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_entrada_digito.sv
// Bench for entrada_digito: directed scenarios plus random bouncing,
// compared against a run-length debounce reference model.
module tb_entrada_digito;

  localparam int D = 4;

  logic       clk;
  logic       reset;
  logic       botao;
  logic [3:0] chaves;
  logic       insere;
  logic [3:0] numero;
  logic       invalido;

  entrada_digito #(.DEBOUNCE_CYCLES(D), .CNT_W(20)) dut (
    .clk      (clk),
    .reset    (reset),
    .botao    (botao),
    .chaves   (chaves),
    .insere   (insere),
    .numero   (numero),
    .invalido (invalido)
  );

  always #5 clk = ~clk;

  // Reference: an accepted level flips after D+1 consecutive
  // edges whose synchronised sample disagrees with it.
  logic       mb1, mb2;
  logic [3:0] mc1, mc2;
  logic       m_level;
  int         m_run;
  int         m_npulse;
  logic       e_ins, e_inv;
  logic [3:0] e_num;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mb1 <= 0; mb2 <= 0; mc1 <= 0; mc2 <= 0;
      m_level <= 1; m_run <= 0;
      e_ins <= 0; e_inv <= 0; e_num <= 0;
    end else begin
      e_ins <= 0;
      e_inv <= 0;
      if (mb2 != m_level) begin
        if (m_run + 1 == D + 1) begin
          m_level <= mb2;
          m_run   <= 0;
          if (mb2) begin
            m_npulse <= m_npulse + 1;
            if (mc2 <= 9) begin
              e_ins <= 1;
              e_num <= mc2;
            end else begin
              e_inv <= 1;
            end
          end
        end else begin
          m_run <= m_run + 1;
        end
      end else begin
        m_run <= 0;
      end
      mb2 <= mb1; mb1 <= botao;
      mc2 <= mc1; mc1 <= chaves;
    end
  end

  int n_chk, n_pass;
  int edge_n, first_ins;
  int c_ins, c_inv, c_both, c_diff;
  logic [3:0] q_num[$];

  task automatic clear();
    edge_n = 0; first_ins = -1;
    c_ins = 0; c_inv = 0; c_both = 0; c_diff = 0;
    q_num.delete();
  endtask

  task automatic tick();
    @(posedge clk);
    edge_n++;
    @(negedge clk);
    if (insere === 1'b1) begin
      c_ins++;
      q_num.push_back(numero);
      if (first_ins < 0) first_ins = edge_n;
    end
    if (invalido === 1'b1) c_inv++;
    if (insere === 1'b1 && invalido === 1'b1) c_both++;
    if (insere !== e_ins || invalido !== e_inv || numero !== e_num)
      c_diff++;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    reset = 1; botao = 0; chaves = 4'd7;
    ticks(3);
    n_chk++;
    if (insere !== 1'b0) $display("FAIL rst_insere got=%b exp=0", insere);
    else n_pass++;
    n_chk++;
    if (invalido !== 1'b0) $display("FAIL rst_invalido got=%b exp=0", invalido);
    else n_pass++;
    n_chk++;
    if (numero !== 4'd0) $display("FAIL rst_numero got=%0d exp=0", numero);
    else n_pass++;
    reset = 0;
    ticks(10);
  endtask

  task automatic test_clean_press();
    clear();
    chaves = 4'd5; botao = 1;
    ticks(20);
    n_chk++;
    if (first_ins !== 7) $display("FAIL clean_latency got=%0d exp=7", first_ins);
    else n_pass++;
    n_chk++;
    if (c_ins !== 1) $display("FAIL clean_count got=%0d exp=1", c_ins);
    else n_pass++;
    n_chk++;
    if (c_inv !== 0) $display("FAIL clean_inv got=%0d exp=0", c_inv);
    else n_pass++;
    chaves = 4'd3;
    ticks(4);
    n_chk++;
    if (numero !== 4'd5) $display("FAIL clean_numero got=%0d exp=5", numero);
    else n_pass++;
    botao = 0;
    ticks(10);
    n_chk++;
    if (c_diff !== 0) $display("FAIL clean_model got=%0d exp=0", c_diff);
    else n_pass++;
  endtask

  task automatic test_bounce();
    clear();
    chaves = 4'd8;
    botao = 1; tick();
    botao = 1; tick();
    botao = 0; tick();
    botao = 1;
    ticks(20);
    n_chk++;
    if (first_ins !== 10) $display("FAIL bounce_latency got=%0d exp=10", first_ins);
    else n_pass++;
    n_chk++;
    if (c_ins !== 1) $display("FAIL bounce_count got=%0d exp=1", c_ins);
    else n_pass++;
    n_chk++;
    if (numero !== 4'd8) $display("FAIL bounce_numero got=%0d exp=8", numero);
    else n_pass++;
    botao = 0;
    ticks(10);
  endtask

  task automatic test_held();
    clear();
    chaves = 4'd2; botao = 1;
    ticks(50);
    n_chk++;
    if (c_ins !== 1) $display("FAIL held_count got=%0d exp=1", c_ins);
    else n_pass++;
    clear();
    botao = 0; ticks(2);
    botao = 1; ticks(12);
    n_chk++;
    if (c_ins !== 0) $display("FAIL held_short_release got=%0d exp=0", c_ins);
    else n_pass++;
    botao = 0; ticks(8);
    botao = 1; ticks(12);
    n_chk++;
    if (c_ins !== 1) $display("FAIL held_second got=%0d exp=1", c_ins);
    else n_pass++;
    botao = 0; ticks(10);
    n_chk++;
    if (c_diff !== 0) $display("FAIL held_model got=%0d exp=0", c_diff);
    else n_pass++;
  endtask

  task automatic test_invalid();
    chaves = 4'd5; botao = 1; ticks(12);
    botao = 0; ticks(10);
    clear();
    chaves = 4'd12; botao = 1; ticks(12);
    n_chk++;
    if (c_inv !== 1) $display("FAIL inv_count got=%0d exp=1", c_inv);
    else n_pass++;
    n_chk++;
    if (c_ins !== 0) $display("FAIL inv_insere got=%0d exp=0", c_ins);
    else n_pass++;
    n_chk++;
    if (numero !== 4'd5) $display("FAIL inv_numero got=%0d exp=5", numero);
    else n_pass++;
    botao = 0; ticks(10);
  endtask

  task automatic test_reset_mid();
    clear();
    chaves = 4'd6; botao = 1;
    ticks(3);
    reset = 1; tick();
    reset = 0; ticks(20);
    n_chk++;
    if (c_ins !== 0) $display("FAIL rmid_no_pulse got=%0d exp=0", c_ins);
    else n_pass++;
    botao = 0; ticks(8);
    botao = 1; ticks(12);
    n_chk++;
    if (c_ins !== 1) $display("FAIL rmid_after got=%0d exp=1", c_ins);
    else n_pass++;
    n_chk++;
    if (numero !== 4'd6) $display("FAIL rmid_numero got=%0d exp=6", numero);
    else n_pass++;
    botao = 0; ticks(10);
  endtask

  task automatic test_sequence();
    logic [3:0] seq[6];
    seq = '{4'd5, 4'd8, 4'd9, 4'd2, 4'd0, 4'd4};
    clear();
    for (int i = 0; i < 6; i++) begin
      chaves = seq[i];
      botao = 1; ticks(12);
      botao = 0; ticks(10);
    end
    n_chk++;
    if (q_num.size() !== 6) $display("FAIL seq_count got=%0d exp=6", q_num.size());
    else n_pass++;
    n_chk++;
    if (c_inv !== 0) $display("FAIL seq_inv got=%0d exp=0", c_inv);
    else n_pass++;
    for (int i = 0; i < 6 && i < q_num.size(); i++) begin
      n_chk++;
      if (q_num[i] !== seq[i])
        $display("FAIL seq_numero[%0d] got=%0d exp=%0d", i, q_num[i], seq[i]);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    int p0;
    clear();
    p0 = m_npulse;
    for (int ph = 0; ph < 150; ph++) begin
      botao  = 1'($urandom_range(0, 1));
      chaves = 4'($urandom_range(0, 15));
      for (int k = $urandom_range(1, 9); k > 0; k--) begin
        if ($urandom_range(0, 3) == 0) chaves = 4'($urandom_range(0, 15));
        tick();
      end
    end
    botao = 0; ticks(10);
    n_chk++;
    if (c_diff !== 0) $display("FAIL rand_model got=%0d exp=0", c_diff);
    else n_pass++;
    n_chk++;
    if (c_both !== 0) $display("FAIL rand_both got=%0d exp=0", c_both);
    else n_pass++;
    n_chk++;
    if (c_ins + c_inv !== m_npulse - p0)
      $display("FAIL rand_pulses got=%0d exp=%0d", c_ins + c_inv, m_npulse - p0);
    else n_pass++;
  endtask

  initial begin
    clk = 0; reset = 1; botao = 0; chaves = 0;
    n_chk = 0; n_pass = 0; m_npulse = 0;
    clear();
    #1;
    test_reset();
    test_clean_press();
    test_bounce();
    test_held();
    test_invalid();
    test_reset_mid();
    test_sequence();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
